ndarray_window_packer: RTL and testbench
========================================

Name: ndarray_window_packer

Overview:
- Sequencing controller for the dynamic-offset slice-set datapath, which writes a 2-element chunk of 3x2-bit sub-arrays into a 6-slot frame at a runtime offset and zero-fills the remaining slots.
- This block generates that offset, so callers do not supply it.
- It accepts chunks on a valid/ready input, places each chunk at the next offset, and holds the assembled frame in registers.
- It emits the full (or flushed partial) frame on a valid/ready output, sitting between a chunk producer and a frame consumer.

Parameters:
- ELEM_W, 2, bits per innermost element.
- INNER, 3, elements per slot; slot width SLOT_W = ELEM_W*INNER = 6.
- CHUNK, 2, slots per input chunk.
- SLOTS, 6, slots per frame; must be a multiple of CHUNK. Frame width FRAME_W = SLOTS*SLOT_W = 36.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- ASYNCRESETN  input  1  asynchronous, active-low reset.
- in_valid  input  1  chunk valid.
- in_ready  output  1  chunk accepted when in_valid & in_ready.
- in_data  input  CHUNK*SLOT_W (12)  chunk; chunk slot c at bits [c*SLOT_W +: SLOT_W].
- flush  input  1  close the current partial frame.
- out_valid  output  1  frame valid.
- out_ready  input  1  frame consumed when out_valid & out_ready.
- out_data  output  FRAME_W (36)  frame; slot k at [k*SLOT_W +: SLOT_W], element j of slot at [k*SLOT_W + j*ELEM_W +: ELEM_W].
- out_fill  output  $clog2(SLOTS+1) (3)  number of written slots in the current frame.

Behaviour:
- Reset: ASYNCRESETN low clears everything immediately, independent of CLK: state=FILL, off=0, frame=0, in_ready=1, out_valid=0, out_data=0, out_fill=0. Reset mid-frame discards partial data; no frame is emitted.
- State FILL:
  - in_ready=1, out_valid=0.
  - On accept, slot off+c <= in_data chunk slot c for c in 0..CHUNK-1; off <= off+CHUNK.
  - Slots not yet written stay 0.
- FILL -> DRAIN when either:
  - an accept occurs with off == SLOTS-CHUNK (frame full), or
  - flush=1 with off>0 (partial frame).
- flush with off==0 and no accept in the same cycle is ignored.
- flush coincident with an accept: the chunk is written first, then the block enters DRAIN. The frame includes that chunk.
- State DRAIN:
  - in_ready=0, out_valid=1, out_data=frame, out_fill=off.
  - out_data and out_fill are stable until the handshake; flush is ignored.
  - On out_ready: -> FILL, off <= 0, frame <= 0, out_fill <= 0.
- Latency: out_valid rises the cycle after the final accept or flush. Full-frame throughput is 3 accepts + 1 drain = 4 cycles per frame.
- No input is accepted in the cycle out_ready completes; in_ready rises the following cycle.
- Outputs are registered: out_data directly from the frame register; in_ready and out_valid decoded from the state register only, with no combinational in_valid->in_ready or out_ready->out_valid paths.
- out_fill = off in all states; its range is 0..SLOTS in steps of CHUNK.
- Arithmetic: off is $clog2(SLOTS+1) bits unsigned and never exceeds SLOTS, so there is no wrap.

Optional Feature:
- Macro: PACKER_STATS_EN.
- When defined, adds output frame_count, 16 bits, reset 0. It increments by 1 on each out_valid & out_ready, full or partial, and wraps 0xFFFF -> 0x0000.
- Also adds output partial_count, 16 bits, counting only flushed frames with off < SLOTS, with the same wrap rule.
- When undefined, neither port nor their counters exist; all other behaviour is identical.

Test Plan:
- Fill: reset, then send chunks 0x041, 0x0C3, 0xFFF back-to-back with out_ready=0 -> out_valid rises the cycle after the third accept. out_data = {0xFFF, 0x0C3, 0x041} (slot 0 = 0x01), out_fill=6, in_ready=0 held. Assert out_ready -> one handshake, then in_ready=1 and out_fill=0 the next cycle.
- Flush: send one chunk 0xABC then pulse flush -> out_data = 36'h0_0000_0ABC, out_fill=2.
- Flush with chunk: flush coincident with the second accept (0x123) -> out_fill=4, slots 2..3 = 0x123, slots 4..5 = 0.
- Ignored flush: flush at off=0 -> no out_valid, state unchanged. Flush during DRAIN -> no effect.
- Backpressure: hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0, in_valid pulses ignored. Next frame starts zero-filled.
- Async reset: assert ASYNCRESETN low between clock edges during DRAIN and mid-fill -> out_valid=0 and out_data=0 immediately. With PACKER_STATS_EN, both counters read 0. After 65536 frames, frame_count wraps to 0.

Source files
------------

// File: rtl/ndarray_window_packer.sv
//==============================================================================
// Module      : ndarray_window_packer
// Description : Packs CHUNK-slot input chunks into a SLOTS-slot frame at a
//               self-generated offset, zero-filling unwritten slots, and emits
//               full or flushed partial frames on a valid/ready output.
//               Optional macro PACKER_STATS_EN adds frame/partial counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ndarray_window_packer #(
    parameter  int ELEM_W  = 2,
    parameter  int INNER   = 3,
    parameter  int CHUNK   = 2,
    parameter  int SLOTS   = 6,
    localparam int SLOT_W  = ELEM_W * INNER,
    localparam int FRAME_W = SLOTS * SLOT_W,
    localparam int CNT_W   = $clog2(SLOTS + 1)
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESETN,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHUNK*SLOT_W-1:0]   in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAME_W-1:0]        out_data,
    output logic [CNT_W-1:0]          out_fill
`ifdef PACKER_STATS_EN
    ,
    output logic [15:0]               frame_count,
    output logic [15:0]               partial_count
`endif
);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    localparam logic [CNT_W-1:0] C_CHUNK     = CNT_W'(CHUNK);
    localparam logic [CNT_W-1:0] C_LAST_OFF  = CNT_W'(SLOTS - CHUNK);
    localparam logic [CNT_W-1:0] C_SLOTS     = CNT_W'(SLOTS);

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   off_q,   off_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic w_accept;
    logic w_handshake;

    assign w_accept    = (state_q == S_FILL)  && in_valid;
    assign w_handshake = (state_q == S_DRAIN) && out_ready;

    // State register
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accept coincident with flush still lands in the frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if ((w_accept && (off_q == C_LAST_OFF)) ||
                    (flush && (w_accept || (off_q != '0)))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Output decode from state only, so no combinational handshake paths
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_FILL:  in_ready  = 1'b1;
            S_DRAIN: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        frame_d = frame_q;
        off_d   = off_q;
        if (w_accept) begin
            for (int k = 0; k < SLOTS; k++) begin
                for (int c = 0; c < CHUNK; c++) begin
                    if (k == int'(off_q) + c) begin
                        frame_d[k*SLOT_W +: SLOT_W] = in_data[c*SLOT_W +: SLOT_W];
                    end
                end
            end
            off_d = off_q + C_CHUNK;
        end else if (w_handshake) begin
            frame_d = '0;
            off_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            frame_q <= '0;
            off_q   <= '0;
        end else begin
            frame_q <= frame_d;
            off_q   <= off_d;
        end
    end

    assign out_data = frame_q;
    assign out_fill = off_q;

`ifdef PACKER_STATS_EN
    logic [15:0] frame_count_q;
    logic [15:0] partial_count_q;

    // Counters wrap naturally at 16 bits
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            frame_count_q   <= '0;
            partial_count_q <= '0;
        end else if (w_handshake) begin
            frame_count_q <= frame_count_q + 16'd1;
            if (off_q < C_SLOTS) begin
                partial_count_q <= partial_count_q + 16'd1;
            end
        end
    end

    assign frame_count   = frame_count_q;
    assign partial_count = partial_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ndarray_window_packer.sv
// Randomized bench for ndarray_window_packer against a slot-array reference model.
`default_nettype none

module tb_ndarray_window_packer;

    localparam int SLOT_W  = 6;
    localparam int SLOTS   = 6;
    localparam int FRAME_W = 36;

    logic                CLK = 1'b0;
    logic                ASYNCRESETN = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [11:0]         in_data = '0;
    logic                flush = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [FRAME_W-1:0]  out_data;
    logic [2:0]          out_fill;
`ifdef PACKER_STATS_EN
    logic [15:0]         frame_count;
    logic [15:0]         partial_count;
`endif

    ndarray_window_packer dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_fill    (out_fill)
`ifdef PACKER_STATS_EN
        ,
        .frame_count   (frame_count),
        .partial_count (partial_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is a list of slots plus a write cursor
    bit          m_drain;
    int          m_off;
    logic [5:0]  m_slot [SLOTS];
    int          m_frames;
    int          m_partials;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FRAME_W-1:0] model_frame();
        logic [FRAME_W-1:0] f = '0;
        for (int k = 0; k < SLOTS; k++) f[k*SLOT_W +: SLOT_W] = m_slot[k];
        return f;
    endfunction

    task automatic model_clear_frame();
        m_off = 0;
        for (int k = 0; k < SLOTS; k++) m_slot[k] = '0;
    endtask

    task automatic model_reset();
        m_drain    = 1'b0;
        m_frames   = 0;
        m_partials = 0;
        model_clear_frame();
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "/in_ready"},  64'(in_ready),  64'(!m_drain));
        check_eq({tag, "/out_valid"}, 64'(out_valid), 64'(m_drain));
        check_eq({tag, "/out_data"},  64'(out_data),  64'(model_frame()));
        check_eq({tag, "/out_fill"},  64'(out_fill),  64'(m_off));
`ifdef PACKER_STATS_EN
        check_eq({tag, "/frame_count"},   64'(frame_count),   64'(m_frames & 16'hFFFF));
        check_eq({tag, "/partial_count"}, 64'(partial_count), 64'(m_partials & 16'hFFFF));
`endif
    endtask

    // One clock: drive inputs, advance the model, sample after the edge
    task automatic step(input logic v, input logic [11:0] d, input logic f, input logic r,
                        input string tag);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        if (!m_drain) begin
            if (v) begin
                m_slot[m_off]     = d[5:0];
                m_slot[m_off + 1] = d[11:6];
                m_off += 2;
            end
            if ((v && m_off == SLOTS) || (f && m_off > 0)) m_drain = 1'b1;
        end else if (r) begin
            m_frames++;
            if (m_off < SLOTS) m_partials++;
            m_drain = 1'b0;
            model_clear_frame();
        end
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    // Called at posedge+1: pull reset low between edges and check immediately
    task automatic async_reset(input string tag);
        #3;
        ASYNCRESETN = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, "/immediate"});
        check_eq({tag, "/valid_low"}, 64'(out_valid), 64'd0);
        #1;
        ASYNCRESETN = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge CLK);
        #1;
        check_outputs({tag, "/after"});
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;
        check_outputs("reset_release");

        // Full frame, back-to-back
        step(1'b1, 12'h041, 1'b0, 1'b0, "fill0");
        step(1'b1, 12'h0C3, 1'b0, 1'b0, "fill1");
        check_eq("fill_not_yet_valid", 64'(out_valid), 64'd0);
        step(1'b1, 12'hFFF, 1'b0, 1'b0, "fill2");
        check_eq("full_frame_data", 64'(out_data), 64'h0_FFF0_C304_1);
        check_eq("full_frame_fill", 64'(out_fill), 64'd6);
        step(1'b1, 12'h555, 1'b0, 1'b0, "drain_hold");
        step(1'b0, 12'h000, 1'b0, 1'b1, "drain_hs");
        check_eq("post_hs_in_ready", 64'(in_ready), 64'd1);
        check_eq("post_hs_fill", 64'(out_fill), 64'd0);

        // Flush of a one-chunk partial frame
        step(1'b1, 12'hABC, 1'b0, 1'b0, "flush_chunk");
        step(1'b0, 12'h000, 1'b1, 1'b0, "flush_pulse");
        check_eq("flush_data", 64'(out_data), 64'h0_0000_0ABC);
        check_eq("flush_fill", 64'(out_fill), 64'd2);
        step(1'b0, 12'h000, 1'b1, 1'b0, "flush_in_drain");
        step(1'b0, 12'h000, 1'b0, 1'b1, "flush_hs");

        // Flush coincident with the second accept
        step(1'b1, 12'h111, 1'b0, 1'b0, "fwc0");
        step(1'b1, 12'h123, 1'b1, 1'b0, "fwc1");
        check_eq("fwc_fill", 64'(out_fill), 64'd4);
        check_eq("fwc_slots23", 64'(out_data[23:12]), 64'h123);
        check_eq("fwc_slots45", 64'(out_data[35:24]), 64'h0);

        // Backpressure: 10 cycles of stall with stray in_valid pulses
        for (int i = 0; i < 10; i++)
            step(1'($urandom_range(0, 1)), 12'($urandom), 1'b0, 1'b0, "backpressure");
        check_eq("bp_stable", 64'(out_data), 64'h0_0000_0123_111);
        step(1'b0, 12'h000, 1'b0, 1'b1, "bp_hs");

        // Ignored flush at offset 0
        step(1'b0, 12'h000, 1'b1, 1'b0, "flush_empty");
        check_eq("flush_empty_valid", 64'(out_valid), 64'd0);

        // Next frame starts zero-filled
        step(1'b1, 12'h7E5, 1'b1, 1'b0, "zero_fill");
        check_eq("zero_fill_data", 64'(out_data), 64'h0_0000_07E5);

        // Async reset during DRAIN and mid-fill
        async_reset("arst_drain");
        step(1'b1, 12'h9A9, 1'b0, 1'b0, "midfill0");
        step(1'b1, 12'h3C3, 1'b0, 1'b0, "midfill1");
        async_reset("arst_fill");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 12'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, "random");
        end

        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
